// File: rtl/ce_step_gen.sv
// Clock-enable generator: prescaled free-run CE, or one debounced CE per button press.
// The debounce FSM runs in both modes; only the CE source depends on MODE.
//
// state      | meaning
// -----------+------------------------------------------------------
// ST_STABLE0 | button settled low, BTN_DB=0
// ST_CHK1    | BTN_S went high, counting stable-high samples, BTN_DB=0
// ST_STABLE1 | button settled high, BTN_DB=1
// ST_CHK0    | BTN_S went low, counting stable-low samples, BTN_DB=1
module ce_step_gen #(
  parameter int DIV_W  = 16,
  parameter int DB_CNT = 20
) (
  input  logic             CLK,
  input  logic             R,
  input  logic             MODE,
  input  logic             RUN,
  input  logic [DIV_W-1:0] DIV,
  input  logic             BTN,
  output logic             BTN_DB,
  output logic             CE
);

  localparam int CW = $clog2(DB_CNT + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CNT - 1);

  localparam logic [1:0] ST_STABLE0 = 2'd0;
  localparam logic [1:0] ST_CHK1    = 2'd1;
  localparam logic [1:0] ST_STABLE1 = 2'd2;
  localparam logic [1:0] ST_CHK0    = 2'd3;

  logic             btn_m;
  logic             btn_s;
  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CW-1:0]    db_cnt;
  logic [CW-1:0]    db_cnt_nxt;
  logic [CW-1:0]    db_inc;
  logic             btn_db_nxt;
  logic             press;
  logic [DIV_W-1:0] cnt;
  logic             mode_q;

  assign db_inc = db_cnt + CW'(1);

  // The sample that enters CHKx counts as the first stable one, so the level
  // flips after exactly DB_CNT consecutive agreeing samples of BTN_S.
  always_comb begin
    state_nxt  = state;
    db_cnt_nxt = db_cnt;
    press      = 1'b0;
    case (state)
      ST_STABLE0: begin
        if (btn_s) begin
          if (DB_CNT == 1) begin
            state_nxt = ST_STABLE1;
            press     = 1'b1;
          end else begin
            state_nxt  = ST_CHK1;
            db_cnt_nxt = '0;
          end
        end
      end
      ST_CHK1: begin
        if (!btn_s) begin
          state_nxt = ST_STABLE0;
        end else if (db_inc == DB_LAST) begin
          state_nxt = ST_STABLE1;
          press     = 1'b1;
        end else begin
          db_cnt_nxt = db_inc;
        end
      end
      ST_STABLE1: begin
        if (!btn_s) begin
          if (DB_CNT == 1) begin
            state_nxt = ST_STABLE0;
          end else begin
            state_nxt  = ST_CHK0;
            db_cnt_nxt = '0;
          end
        end
      end
      ST_CHK0: begin
        if (btn_s) begin
          state_nxt = ST_STABLE1;
        end else if (db_inc == DB_LAST) begin
          state_nxt = ST_STABLE0;
        end else begin
          db_cnt_nxt = db_inc;
        end
      end
      default: state_nxt = ST_STABLE0;
    endcase
  end

  assign btn_db_nxt = (state_nxt == ST_STABLE1) || (state_nxt == ST_CHK0);

  always_ff @(posedge CLK) begin
    if (R) begin
      btn_m  <= 1'b0;
      btn_s  <= 1'b0;
      state  <= ST_STABLE0;
      db_cnt <= '0;
      BTN_DB <= 1'b0;
      CE     <= 1'b0;
      cnt    <= '0;
      mode_q <= MODE;
    end else begin
      btn_m  <= BTN;
      btn_s  <= btn_m;
      state  <= state_nxt;
      db_cnt <= db_cnt_nxt;
      BTN_DB <= btn_db_nxt;
      mode_q <= MODE;
      if (MODE != mode_q) begin
        cnt <= '0;
        CE  <= 1'b0;
      end else if (MODE) begin
        cnt <= '0;
        CE  <= press;
      end else if (RUN) begin
        // >= rather than == so a DIV lowered below CNT wraps at once
        if (cnt >= DIV) begin
          cnt <= '0;
          CE  <= 1'b1;
        end else begin
          cnt <= cnt + DIV_W'(1);
          CE  <= 1'b0;
        end
      end else begin
        CE <= 1'b0;
      end
    end
  end

endmodule
